d_ctrl: RTL and testbench

D_CTRL -- requirements
Module: d_ctrl

---
 rtl/d_ctrl_pkg.sv | 35 +++
 rtl/d_ctrl_timer.sv | 29 ++
 rtl/d_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_d_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_ctrl_pkg.sv
// D-line round controller shared types.
// State encoding and default sizing.
package d_ctrl_pkg;

  localparam int unsigned DEF_RAM_BLOCKS   = 8;
  localparam logic [15:0] DEF_BUSY_TIMEOUT = 16'd50000;
  localparam int unsigned TMR_W            = 16;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RD_CMD    = 4'd1;
  localparam logic [3:0] ST_RD_DATA   = 4'd2;
  localparam logic [3:0] ST_RD_STOP   = 4'd3;
  localparam logic [3:0] ST_PROC      = 4'd4;
  localparam logic [3:0] ST_PROC_WAIT = 4'd5;
  localparam logic [3:0] ST_WR_CMD    = 4'd6;
  localparam logic [3:0] ST_WR_BUSY   = 4'd7;
  localparam logic [3:0] ST_WR_LAST   = 4'd8;
  localparam logic [3:0] ST_WR_STOP   = 4'd9;
  localparam logic [3:0] ST_DONE      = 4'd10;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    RD_CMD    = ST_RD_CMD,
    RD_DATA   = ST_RD_DATA,
    RD_STOP   = ST_RD_STOP,
    PROC      = ST_PROC,
    PROC_WAIT = ST_PROC_WAIT,
    WR_CMD    = ST_WR_CMD,
    WR_BUSY   = ST_WR_BUSY,
    WR_LAST   = ST_WR_LAST,
    WR_STOP   = ST_WR_STOP,
    DONE      = ST_DONE
  } state_t;

endpackage

// File: rtl/d_ctrl_timer.sv
// Saturating wait timer for command and busy phases.
// A clear restarts counting with the current cycle.
module d_timer
  import d_ctrl_pkg::*;
(
  input  logic             iclk,
  input  logic             irst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      count <= '0;
    end else if (clr) begin
      count <= {{(TMR_W-1){1'b0}}, en};
    end else if (en && (count != '1)) begin
      count <= count + TMR_W'(1);
    end
  end

  // a stale count from the previous phase must not fire
  assign expired = en && !clr && (count >= limit);

endmodule

// File: rtl/d_ctrl.sv
// Read-process-write round sequencer for the SD D-line path.
// Drives command requests, driver starts and block processing.
module d_ctrl
  import d_ctrl_pkg::*;
#(
  parameter int unsigned RAM_BLOCKS   = DEF_RAM_BLOCKS,
  parameter logic [15:0] BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
)(
  input  logic                          iclk,
  input  logic                          irst,
  input  logic                          istart,
  output logic                          ocmd_read_req,
  output logic                          ocmd_write_req,
  output logic                          ocmd_stop_req,
  input  logic                          icmd_done,
  output logic                          odrv_start,
  input  logic                          iread_done,
  input  logic                          iwrite_done,
  input  logic                          icheck_status,
  input  logic                          id0,
  output logic                          oproc_start,
  output logic [$clog2(RAM_BLOCKS)-1:0] oproc_sel,
  input  logic                          iproc_done,
  output logic                          odone,
  output logic                          oerror
);

  localparam int unsigned BW = $clog2(RAM_BLOCKS);
  localparam logic [BW-1:0] BLK_LAST = BW'(RAM_BLOCKS - 1);

  state_t        state;
  logic [BW-1:0] blk;
  logic          armed;
  logic          d0_q;
  logic          wd_q;
  logic          tclr;
  logic          live;
  logic          tmr_en;
  logic          tmr_exp;

  assign oproc_sel = blk;

  always_comb begin
    tmr_en = 1'b0;
    unique case (state)
      RD_CMD, RD_STOP, WR_CMD,
      WR_LAST, WR_STOP: tmr_en = 1'b1;
      WR_BUSY:          tmr_en = armed;
      default:          tmr_en = 1'b0;
    endcase
  end

  d_timer u_timer (
    .iclk    (iclk),
    .irst    (irst),
    .clr     (tclr),
    .en      (tmr_en),
    .limit   (BUSY_TIMEOUT),
    .expired (tmr_exp)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state          <= IDLE;
      blk            <= '0;
      armed          <= 1'b0;
      d0_q           <= 1'b0;
      wd_q           <= 1'b0;
      tclr           <= 1'b0;
      live           <= 1'b0;
      ocmd_read_req  <= 1'b0;
      ocmd_write_req <= 1'b0;
      ocmd_stop_req  <= 1'b0;
      odrv_start     <= 1'b0;
      oproc_start    <= 1'b0;
      odone          <= 1'b0;
      oerror         <= 1'b0;
    end else begin
      ocmd_read_req  <= 1'b0;
      ocmd_write_req <= 1'b0;
      ocmd_stop_req  <= 1'b0;
      odrv_start     <= 1'b0;
      oproc_start    <= 1'b0;
      odone          <= 1'b0;
      tclr           <= 1'b0;
      live           <= 1'b1;
      d0_q           <= id0;
      wd_q           <= iwrite_done;
      unique case (state)
        IDLE: begin
          // first edge out of reset never starts a round
          if (istart && live) begin
            state         <= RD_CMD;
            ocmd_read_req <= 1'b1;
            odrv_start    <= 1'b1;
            oerror        <= 1'b0;
            blk           <= '0;
            tclr          <= 1'b1;
          end
        end
        RD_CMD: begin
          if (icmd_done) begin
            state <= RD_DATA;
            tclr  <= 1'b1;
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        RD_DATA: begin
          if (iread_done) begin
            state         <= RD_STOP;
            ocmd_stop_req <= 1'b1;
            tclr          <= 1'b1;
          end else if (iwrite_done && wd_q) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        RD_STOP: begin
          if (icmd_done) begin
            state <= PROC;
            tclr  <= 1'b1;
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        PROC: begin
          state       <= PROC_WAIT;
          oproc_start <= 1'b1;
          tclr        <= 1'b1;
        end
        PROC_WAIT: begin
          if (iproc_done) begin
            blk  <= blk + BW'(1);
            tclr <= 1'b1;
            if (blk == BLK_LAST) begin
              state          <= WR_CMD;
              ocmd_write_req <= 1'b1;
            end else begin
              state <= PROC;
            end
          end
        end
        WR_CMD: begin
          if (icmd_done) begin
            state      <= WR_BUSY;
            odrv_start <= 1'b1;
            armed      <= 1'b0;
            tclr       <= 1'b1;
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        WR_BUSY: begin
          if (armed && id0 && d0_q) begin
            blk        <= blk + BW'(1);
            odrv_start <= 1'b1;
            armed      <= 1'b0;
            if (blk == BLK_LAST) begin
              state <= WR_LAST;
              tclr  <= 1'b1;
            end
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end else if (icheck_status) begin
            armed <= 1'b1;
            tclr  <= 1'b1;
          end
        end
        WR_LAST: begin
          if (iwrite_done) begin
            state         <= WR_STOP;
            ocmd_stop_req <= 1'b1;
            tclr          <= 1'b1;
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        WR_STOP: begin
          if (icmd_done) begin
            state <= DONE;
            odone <= 1'b1;
            tclr  <= 1'b1;
          end else if (tmr_exp) begin
            state  <= DONE;
            odone  <= 1'b1;
            oerror <= 1'b1;
            tclr   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          tclr  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_ctrl.sv
// Bench for d_ctrl: reactive card/driver model,
// vector table of rounds, scoreboard of processed blocks.
module tb_d_ctrl;
  import d_ctrl_pkg::*;

  localparam int NB = 8;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       istart = 1'b0;
  logic       icmd_done = 1'b0;
  logic       iread_done = 1'b0;
  logic       iwrite_done = 1'b0;
  logic       icheck_status = 1'b0;
  logic       id0 = 1'b1;
  logic       iproc_done = 1'b0;
  logic       ocmd_read_req, ocmd_write_req, ocmd_stop_req;
  logic       odrv_start, oproc_start, odone, oerror;
  logic [2:0] oproc_sel;

  d_ctrl #(.RAM_BLOCKS(NB), .BUSY_TIMEOUT(16'd100)) dut (
    .iclk           (iclk),
    .irst           (irst),
    .istart         (istart),
    .ocmd_read_req  (ocmd_read_req),
    .ocmd_write_req (ocmd_write_req),
    .ocmd_stop_req  (ocmd_stop_req),
    .icmd_done      (icmd_done),
    .odrv_start     (odrv_start),
    .iread_done     (iread_done),
    .iwrite_done    (iwrite_done),
    .icheck_status  (icheck_status),
    .id0            (id0),
    .oproc_start    (oproc_start),
    .oproc_sel      (oproc_sel),
    .iproc_done     (iproc_done),
    .odone          (odone),
    .oerror         (oerror)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    bit crc;
    int rd_dly;
    int busy;
    bit sip;
    bit rst_wr;
    int e_rd;
    int e_wr;
    int e_stop;
    int e_drv;
    int e_proc;
    bit e_err;
    int e_dc;
  } vec_t;

  vec_t       tbl[8];
  int         n_chk, n_fail, cyc, cur_vid, done_cyc;
  int         n_rd, n_wr, n_stop, n_drv, n_proc, n_wdrv;
  bit         s_rd, s_wr, s_stop, s_drv, s_proc, s_done, done_err;
  logic [2:0] exp_sel[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d",
               nm, cur_vid, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({ocmd_read_req, ocmd_write_req, ocmd_stop_req,
                 odrv_start, oproc_start, odone, oerror, oproc_sel});
  endfunction

  task automatic tick();
    @(posedge iclk);
    #1;
    cyc++;
    s_rd   = ocmd_read_req;
    s_wr   = ocmd_write_req;
    s_stop = ocmd_stop_req;
    s_drv  = odrv_start;
    s_proc = oproc_start;
    s_done = odone;
    if (s_rd) n_rd++;
    if (s_wr) n_wr++;
    if (s_stop) n_stop++;
    if (s_drv) n_drv++;
    if (s_proc) begin
      n_proc++;
      chk("proc_expected", int'(exp_sel.size() > 0), 1);
      if (exp_sel.size() > 0)
        chk("proc_sel", int'(oproc_sel), int'(exp_sel.pop_front()));
    end
    if (s_done) begin
      done_err = oerror;
      done_cyc = cyc;
    end
  endtask

  task automatic run_round(input vec_t v);
    int cmd_cd, kind, rd_cd, proc_cd, chk_cd, d0_cd, wd_cd;
    int rise_cyc, start_cyc;
    bit wr_phase, rise_pend, got_done, sip_req, sip_done;
    cmd_cd = -1; kind = 0; rd_cd = -1; proc_cd = -1;
    chk_cd = -1; d0_cd = -1; wd_cd = -1; rise_cyc = 0;
    wr_phase = 0; rise_pend = 0; got_done = 0;
    sip_req = 0; sip_done = 0;
    n_rd = 0; n_wr = 0; n_stop = 0; n_drv = 0;
    n_proc = 0; n_wdrv = 0; done_cyc = 0;
    exp_sel.delete();
    if (v.e_proc == NB)
      for (int i = 0; i < NB; i++) exp_sel.push_back(3'(i));
    istart = 1'b1;
    tick();
    istart = 1'b0;
    start_cyc = cyc;
    if (s_rd && v.rd_dly > 0) begin
      cmd_cd = v.rd_dly;
      kind = 1;
    end
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (v.rst_wr && n_wdrv == 3) break;
      icmd_done = 1'b0;
      iproc_done = 1'b0;
      icheck_status = 1'b0;
      istart = sip_req;
      sip_req = 0;
      if (cmd_cd > 0) begin
        cmd_cd--;
        if (cmd_cd == 0) begin
          icmd_done = 1'b1;
          cmd_cd = -1;
          if (kind == 1) rd_cd = 8;
          if (kind == 2) wr_phase = 1;
        end
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          if (v.crc) iwrite_done = 1'b1;
          else iread_done = 1'b1;
          rd_cd = -1;
        end
      end
      if (proc_cd > 0) begin
        proc_cd--;
        if (proc_cd == 0) begin
          iproc_done = 1'b1;
          proc_cd = -1;
          if (v.sip && !sip_done) begin
            sip_req = 1;
            sip_done = 1;
          end
        end
      end
      if (chk_cd > 0) begin
        chk_cd--;
        if (chk_cd == 0) begin
          icheck_status = 1'b1;
          if (v.busy > 0) begin
            id0 = 1'b0;
            d0_cd = v.busy;
          end
          chk_cd = -1;
        end
      end else if (d0_cd > 0) begin
        d0_cd--;
        if (d0_cd == 0) begin
          id0 = 1'b1;
          rise_cyc = cyc;
          rise_pend = 1;
          d0_cd = -1;
        end
      end
      if (wd_cd > 0) begin
        wd_cd--;
        if (wd_cd == 0) begin
          iwrite_done = 1'b1;
          wd_cd = -1;
        end
      end
      tick();
      if (s_rd || s_wr || s_stop) begin
        kind = s_rd ? 1 : (s_wr ? 2 : 3);
        if (!s_rd) cmd_cd = 5;
      end
      if (s_stop) iread_done = 1'b0;
      if (s_proc) proc_cd = 10;
      if (s_drv && wr_phase) begin
        n_wdrv++;
        if (rise_pend) begin
          chk("busy_release_latency", cyc - rise_cyc, 2);
          rise_pend = 0;
        end
        if (n_wdrv <= NB) chk_cd = 3;
        else wd_cd = 3;
      end
      if (s_done) got_done = 1;
    end
    istart = 1'b0;
    icmd_done = 1'b0;
    iproc_done = 1'b0;
    icheck_status = 1'b0;
    if (!v.rst_wr) begin
      chk("round_finished", int'(got_done), 1);
      chk("read_req_count", n_rd, v.e_rd);
      chk("write_req_count", n_wr, v.e_wr);
      chk("stop_req_count", n_stop, v.e_stop);
      chk("drv_start_count", n_drv, v.e_drv);
      chk("proc_start_count", n_proc, v.e_proc);
      chk("sel_left", exp_sel.size(), 0);
      chk("error_with_done", int'(done_err), int'(v.e_err));
      if (v.e_dc != 0)
        chk("done_cycle", done_cyc - start_cyc, v.e_dc);
      iread_done = 1'b0;
      iwrite_done = 1'b0;
      id0 = 1'b1;
      repeat (3) tick();
      chk("error_level_held", int'(oerror), int'(v.e_err));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    cur_vid = -1;
    //            crc   dly  busy sip   rstwr rd wr st drv prc err   dc
    tbl[0] = '{1'b0,   5,   0, 1'b0, 1'b0, 1, 1, 2, 10, 8, 1'b0,   0};
    tbl[1] = '{1'b0,   5,  50, 1'b0, 1'b0, 1, 1, 2, 10, 8, 1'b0,   0};
    tbl[2] = '{1'b1,   5,   0, 1'b0, 1'b0, 1, 0, 0,  1, 0, 1'b1,   0};
    tbl[3] = '{1'b0,   0,   0, 1'b0, 1'b0, 1, 0, 0,  1, 0, 1'b1, 101};
    tbl[4] = '{1'b0, 101,   0, 1'b0, 1'b0, 1, 1, 2, 10, 8, 1'b0,   0};
    tbl[5] = '{1'b0, 102,   0, 1'b0, 1'b0, 1, 0, 0,  1, 0, 1'b1, 101};
    tbl[6] = '{1'b0,   5,   3, 1'b1, 1'b0, 1, 1, 2, 10, 8, 1'b0,   0};
    tbl[7] = '{1'b0,   5,   0, 1'b0, 1'b1, 0, 0, 0,  0, 8, 1'b0,   0};

    repeat (3) @(posedge iclk);
    #1;
    chk("reset_outputs", outs(), 0);
    irst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 7; i++) begin
      cur_vid = i;
      run_round(tbl[i]);
      repeat (2) tick();
    end

    cur_vid = 7;
    run_round(tbl[7]);
    chk("pre_reset_sel", int'(oproc_sel), 2);
    chk("pre_reset_drv", int'(odrv_start), 1);
    irst = 1'b1;
    #1;
    chk("async_reset_drv", int'(odrv_start), 0);
    chk("async_reset_sel", int'(oproc_sel), 0);
    chk("async_reset_outs", outs(), 0);
    iread_done = 1'b0;
    iwrite_done = 1'b0;
    id0 = 1'b1;
    repeat (2) tick();
    chk("reset_hold_outs", outs(), 0);
    irst = 1'b0;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    chk("first_edge_quiet", outs(), 0);
    tick();
    chk("first_edge_no_start", int'(ocmd_read_req), 0);

    cur_vid = 8;
    run_round(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
